// File: rtl/dist_ram_read_arbiter_pkg.sv
// Shared constants and types for the distributed-RAM read arbiter slice.
// Optional stall statistics are enabled by DIST_RAM_READ_ARB_STATS_EN (see top level).
package dist_ram_pkg;

  localparam int unsigned DEFAULT_ADDR_WIDTH     = 5;
  localparam int unsigned DEFAULT_DATA_WIDTH     = 32;
  localparam int unsigned DEFAULT_NUM_READ_PORTS = 3;
  localparam int unsigned DEFAULT_COUNT_WIDTH    = 16;

  typedef logic [$clog2(DEFAULT_NUM_READ_PORTS)-1:0] port_idx_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dist_ram_read_arbiter_if.sv
// Request/response and RAM read-port bundle between requesters and the arbiter.
// slave = arbiter side, master = requester/RAM side.
interface dist_ram_read_arbiter_if
  import dist_ram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int unsigned NUM_READ_PORTS = DEFAULT_NUM_READ_PORTS,
  parameter int unsigned COUNT_WIDTH    = DEFAULT_COUNT_WIDTH
);

  logic [NUM_READ_PORTS-1:0]                  i_req_valid;
  logic [NUM_READ_PORTS-1:0][ADDR_WIDTH-1:0]  i_req_address;
  logic [NUM_READ_PORTS-1:0]                  o_req_ready;
  logic [NUM_READ_PORTS-1:0]                  o_rsp_valid;
  logic [NUM_READ_PORTS-1:0][DATA_WIDTH-1:0]  o_rsp_data;
  logic [NUM_READ_PORTS-1:0]                  i_rsp_ready;
  logic [ADDR_WIDTH-1:0]                      o_ram_read_address;
  logic [DATA_WIDTH-1:0]                      i_ram_read_data;
  logic [NUM_READ_PORTS-1:0][COUNT_WIDTH-1:0] o_stall_count;

  modport slave (
    input  i_req_valid, i_req_address, i_rsp_ready, i_ram_read_data,
    output o_req_ready, o_rsp_valid, o_rsp_data, o_ram_read_address, o_stall_count
  );

  modport master (
    output i_req_valid, i_req_address, i_rsp_ready, i_ram_read_data,
    input  o_req_ready, o_rsp_valid, o_rsp_data, o_ram_read_address, o_stall_count
  );

endinterface

// File: rtl/dist_ram_read_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from ptr+1 upward, pointer moves to the winner.
// Reusable by any block that shares a single port among N requesters.
module rr_arbiter #(
  parameter int unsigned N     = 2,
  parameter type         idx_t = logic [$clog2(N)-1:0]
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [N-1:0] i_request,
  input  logic         i_advance,
  output logic [N-1:0] o_grant,
  output idx_t         o_grant_idx
);

  localparam idx_t LAST = idx_t'(N - 1);

  idx_t ptr;

  // Walk the search order backwards so the nearest requester after ptr overwrites the rest.
  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    for (int unsigned k = N; k >= 1; k--) begin
      if (i_request[(32'(ptr) + k) % N]) begin
        o_grant                       = '0;
        o_grant[(32'(ptr) + k) % N]   = 1'b1;
        o_grant_idx                   = idx_t'((32'(ptr) + k) % N);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr <= LAST;
    end else if (i_advance && (|i_request)) begin
      ptr <= o_grant_idx;
    end
  end

endmodule

// File: rtl/dist_ram_read_arbiter.sv
// Shares one asynchronous distributed-RAM read port among NUM_READ_PORTS requesters,
// round-robin, 1-cycle latency. Define DIST_RAM_READ_ARB_STATS_EN for saturating stall counters.
module dist_ram_read_arbiter
  import dist_ram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int unsigned NUM_READ_PORTS = DEFAULT_NUM_READ_PORTS,
  parameter int unsigned COUNT_WIDTH    = DEFAULT_COUNT_WIDTH
) (
  input logic                     i_clk,
  input logic                     i_rst_n,
  dist_ram_read_arbiter_if.slave  bus
);

  localparam int unsigned IDX_W = idx_width(NUM_READ_PORTS);
  typedef logic [IDX_W-1:0] idx_t;

  logic [NUM_READ_PORTS-1:0]                 eligible;
  logic [NUM_READ_PORTS-1:0]                 grant;
  idx_t                                      grant_idx;
  logic [NUM_READ_PORTS-1:0]                 rsp_valid;
  logic [NUM_READ_PORTS-1:0][DATA_WIDTH-1:0] rsp_data;

  // A slot that drains this cycle may be refilled in the same cycle.
  always_comb begin
    eligible = bus.i_req_valid & (~rsp_valid | bus.i_rsp_ready);
  end

  rr_arbiter #(
    .N     (NUM_READ_PORTS),
    .idx_t (idx_t)
  ) u_rr_arbiter (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_request   (eligible),
    .i_advance   (1'b1),
    .o_grant     (grant),
    .o_grant_idx (grant_idx)
  );

  always_comb begin
    bus.o_req_ready        = grant;
    bus.o_ram_read_address = '0;
    if (|grant) begin
      bus.o_ram_read_address = bus.i_req_address[grant_idx];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      for (int unsigned p = 0; p < NUM_READ_PORTS; p++) begin
        if (grant[p]) begin
          rsp_valid[p] <= 1'b1;
          rsp_data[p]  <= bus.i_ram_read_data;
        end else if (bus.i_rsp_ready[p]) begin
          rsp_valid[p] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    bus.o_rsp_valid = rsp_valid;
    bus.o_rsp_data  = rsp_data;
  end

`ifdef DIST_RAM_READ_ARB_STATS_EN
  logic [NUM_READ_PORTS-1:0][COUNT_WIDTH-1:0] stall_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_count <= '0;
    end else begin
      for (int unsigned p = 0; p < NUM_READ_PORTS; p++) begin
        if (bus.i_req_valid[p] && !grant[p] && (stall_count[p] != '1)) begin
          stall_count[p] <= stall_count[p] + COUNT_WIDTH'(1);
        end
      end
    end
  end

  always_comb begin
    bus.o_stall_count = stall_count;
  end
`else
  always_comb begin
    bus.o_stall_count = {NUM_READ_PORTS{{COUNT_WIDTH{1'b0}}}};
  end
`endif

endmodule
